// File: rtl/triggerrec_pkg.sv
// -----------------------------------------------------------------------------
// triggerrec_pkg
// Shared definitions for the trigger recorder event FIFO:
//   - ctrl bus register offsets and a decoder to a register-select enum
//   - STATUS read bit positions and STATUS write command bits
//   - stored timestamp width
//   - saturating increment helper for the dropped-event counter
// -----------------------------------------------------------------------------
package triggerrec_pkg;

  localparam logic [15:0] REG_STATUS  = 16'h0000;
  localparam logic [15:0] REG_MASK    = 16'h0004;
  localparam logic [15:0] REG_HEAD_TS = 16'h0008;
  localparam logic [15:0] REG_HEAD_IO = 16'h000C;

  // STATUS read layout
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_DROP_LSB  = 16;

  // STATUS write command bits
  localparam int STATUS_WR_CLEAR_BIT = 0;
  localparam int STATUS_WR_FLUSH_BIT = 1;

  // Only the low word of the free-running counter is kept per entry
  localparam int TS_WIDTH = 32;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_STATUS  = 3'd1,
    SEL_MASK    = 3'd2,
    SEL_HEAD_TS = 3'd3,
    SEL_HEAD_IO = 3'd4
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [15:0] addr);
    reg_sel_e sel;
    case (addr)
      REG_STATUS:  sel = SEL_STATUS;
      REG_MASK:    sel = SEL_MASK;
      REG_HEAD_TS: sel = SEL_HEAD_TS;
      REG_HEAD_IO: sel = SEL_HEAD_IO;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/triggerrec_event_fifo_if.sv
// -----------------------------------------------------------------------------
// triggerrec_event_fifo_if
// icosoc ctrl bus as seen by the event FIFO.
//   ctrl_wr   : byte write strobes (any bit set = write)
//   ctrl_rd   : read request
//   ctrl_addr : byte address
//   ctrl_wdat : write data
//   ctrl_rdat : registered read data
//   ctrl_done : one-cycle completion pulse
// master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface triggerrec_event_fifo_if;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface

// File: rtl/triggerrec_sync_fifo.sv
// -----------------------------------------------------------------------------
// triggerrec_sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
//   clk, resetn : clock, async active-low reset (empties the FIFO)
//   push, push_data : write request and data
//   pop         : read request (ignored while empty)
//   flush       : empties the FIFO; overrides a same-cycle push/pop
//   count       : occupancy, log2(DEPTH)+1 bits
//   full, empty : occupancy flags
//   head        : data at the read pointer
// A push while full is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module triggerrec_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against occupancy (pop frees a slot for a same-cycle push)
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/triggerrec_event_fifo.sv
// -----------------------------------------------------------------------------
// triggerrec_event_fifo
// Edge-capture stage: compares each sampled IO vector with the previous one
// and, on a change in any enabled channel, logs {timestamp[31:0], io_in}
// into a FIFO drained by the CPU over the ctrl bus.
//   clk, resetn : clock, async active-low reset
//   io_in       : sampled pin vector (clk domain)
//   timestamp   : free-running counter, low 32 bits stored
//   ctrl        : ctrl bus slave (STATUS/MASK/HEAD_TS/HEAD_IO)
//   irq         : high while the FIFO holds at least one entry
// -----------------------------------------------------------------------------
module triggerrec_event_fifo
  import triggerrec_pkg::*;
#(
  parameter int IO_LENGTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IO_LENGTH-1:0] io_in,
  input  logic [63:0]          timestamp,
  triggerrec_event_fifo_if.slave ctrl,
  output logic                 irq
);

  localparam int ENTRY_W = TS_WIDTH + IO_LENGTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [IO_LENGTH-1:0] io_prev_r;
  logic                 primed_r;
  logic [IO_LENGTH-1:0] mask_r;
  logic                 overflow_r;
  logic [15:0]          drop_cnt_r;
  logic                 ctrl_done_r;
  logic [31:0]          ctrl_rdat_r;
  logic                 irq_r;

  logic [CNT_W-1:0]     fifo_count_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [ENTRY_W-1:0]   fifo_head_s;

  reg_sel_e             sel_s;
  logic                 req_s;
  logic                 rd_s;
  logic                 wr_s;
  logic                 pop_s;
  logic                 flush_s;
  logic                 clr_s;
  logic                 mask_wr_s;
  logic                 event_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 overflow_nxt_s;
  logic [15:0]          drop_cnt_nxt_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic [31:0]          status_s;
  logic [31:0]          rdat_s;
  logic                 ctrl_unused_s;

  assign ctrl.ctrl_done = ctrl_done_r;
  assign ctrl.ctrl_rdat = ctrl_rdat_r;
  assign irq            = irq_r;
  assign ctrl_unused_s  = ^{timestamp[63:TS_WIDTH], ctrl.ctrl_wdat};

  triggerrec_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .push_data ({timestamp[TS_WIDTH-1:0], io_in}),
    .pop       (pop_s),
    .flush     (flush_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  // Request decode, edge detection, FIFO control and bookkeeping next-state
  always_comb begin
    // A request is only taken while no completion is pending, so a request
    // held across its own done cycle cannot pop twice.
    req_s     = ((ctrl.ctrl_wr != 4'b0000) || ctrl.ctrl_rd) && !ctrl_done_r;
    sel_s     = decode_reg(ctrl.ctrl_addr);
    rd_s      = req_s && ctrl.ctrl_rd;
    wr_s      = req_s && (ctrl.ctrl_wr != 4'b0000);
    pop_s     = rd_s && (sel_s == SEL_HEAD_IO) && !fifo_empty_s;
    flush_s   = wr_s && (sel_s == SEL_STATUS) && ctrl.ctrl_wdat[STATUS_WR_FLUSH_BIT];
    clr_s     = wr_s && (sel_s == SEL_STATUS) && ctrl.ctrl_wdat[STATUS_WR_CLEAR_BIT];
    mask_wr_s = wr_s && (sel_s == SEL_MASK);

    event_s = primed_r && (((io_in ^ io_prev_r) & mask_r) != {IO_LENGTH{1'b0}});
    // Flush discards a same-cycle event outright: it is neither stored nor dropped.
    push_s  = event_s && !flush_s && (!fifo_full_s || pop_s);
    drop_s  = event_s && !flush_s && fifo_full_s && !pop_s;

    // A drop in the same cycle as a clear leaves exactly one drop recorded.
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (clr_s) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end

    if (drop_s) begin
      if (clr_s) begin
        drop_cnt_nxt_s = 16'd1;
      end else begin
        drop_cnt_nxt_s = sat_inc16(drop_cnt_r);
      end
    end else if (clr_s) begin
      drop_cnt_nxt_s = 16'd0;
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end

    if (flush_s) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      count_nxt_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Read data mux; STATUS shows the state after this edge so an event
  // captured on the same edge as the read is already counted.
  always_comb begin
    status_s                                = 32'h0000_0000;
    status_s[STATUS_EMPTY_BIT]              = (count_nxt_s == {CNT_W{1'b0}});
    status_s[STATUS_FULL_BIT]               = (count_nxt_s == CNT_W'(FIFO_DEPTH));
    status_s[STATUS_OVF_BIT]                = overflow_nxt_s;
    status_s[STATUS_COUNT_LSB +: 8]         = 8'(count_nxt_s);
    status_s[STATUS_DROP_LSB +: 16]         = drop_cnt_nxt_s;

    rdat_s = 32'h0000_0000;
    if (rd_s) begin
      case (sel_s)
        SEL_STATUS:  rdat_s = status_s;
        SEL_MASK:    rdat_s = 32'(mask_r);
        SEL_HEAD_TS: rdat_s = fifo_empty_s ? 32'h0000_0000
                                           : fifo_head_s[ENTRY_W-1:IO_LENGTH];
        SEL_HEAD_IO: rdat_s = fifo_empty_s ? 32'h0000_0000
                                           : 32'(fifo_head_s[IO_LENGTH-1:0]);
        default:     rdat_s = 32'h0000_0000;
      endcase
    end else begin
      rdat_s = 32'h0000_0000;
    end
  end

  // Previous-sample register and first-cycle priming
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io_prev_r <= {IO_LENGTH{1'b0}};
      primed_r  <= 1'b0;
    end else begin
      io_prev_r <= io_in;
      primed_r  <= 1'b1;
    end
  end

  // Channel mask, sticky overflow and saturating drop counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_r     <= {IO_LENGTH{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (mask_wr_s) begin
        mask_r <= ctrl.ctrl_wdat[IO_LENGTH-1:0];
      end
      overflow_r <= overflow_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  // Registered ctrl completion, read data and interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done_r <= 1'b0;
      ctrl_rdat_r <= 32'h0000_0000;
      irq_r       <= 1'b0;
    end else begin
      ctrl_done_r <= req_s;
      ctrl_rdat_r <= rdat_s;
      irq_r       <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

endmodule
